// File: rtl/row_cache_pkg.sv
// Shared types and default widths for the row-cache arbiter.
package row_cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int DEF_ADDRWIDTH = 17;
  localparam int DEF_CROWWIDTH = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first active request at or after ptr wins; one-hot grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = IDW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/row_cache_arbiter.sv
// Arbitrates NREQ requesters onto a single row-cache port, one request in flight.
// Optional WAIT timeout is enabled by defining ROW_CACHE_ARB_TIMEOUT_EN.
module row_cache_arbiter
  import row_cache_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH,
  parameter int CROWWIDTH = DEF_CROWWIDTH,
  parameter int TIMEOUT   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_wr,
  input  logic [NREQ*ADDRWIDTH-1:0] req_row,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [CROWWIDTH-1:0]      rsp_crow,
  output logic                      rsp_err,
  input  logic                      MemOK,
  output logic                      cache_RD,
  output logic                      cache_WR,
  output logic [ADDRWIDTH-1:0]      cache_RowId,
  input  logic                      cache_hold,
  input  logic [CROWWIDTH-1:0]      cache_cRowId,
  output state_e                    dbg_state
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a requester holds req_valid with its row/wr stable; the cycle
  // req_ready[i] pulses is the accept cycle, and the request is then owned here
  // until rsp_valid[i] pulses. req_valid is only looked at in IDLE.

  state_e                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         id_q, id_d;
  logic [ADDRWIDTH-1:0]   row_q, row_d;
  logic                   wr_q, wr_d;
  logic [CROWWIDTH-1:0]   crow_q, crow_d;

  logic [NREQ-1:0]        grant;
  logic [IDW-1:0]         win_id;
  logic [ADDRWIDTH-1:0]   win_row;
  logic                   win_wr;
  logic                   timeout_hit;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    win_id  = '0;
    win_row = '0;
    win_wr  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_id  = IDW'(i);
        win_row = req_row[i*ADDRWIDTH +: ADDRWIDTH];
        win_wr  = req_wr[i];
      end
    end
  end

`ifdef ROW_CACHE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;

  // Counter sits at 0 outside WAIT, so WAIT cycle k sees cnt_q == k-1.
  assign timeout_hit = (state_q == WAIT) && cache_hold && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      if (state_q == WAIT) err_q <= timeout_hit;
    end
  end

  assign rsp_err = (state_q == RESP) && err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      row_q   <= '0;
      wr_q    <= 1'b0;
      crow_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      row_q   <= row_d;
      wr_q    <= wr_d;
      crow_q  <= crow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    row_d   = row_q;
    wr_d    = wr_q;
    crow_d  = crow_q;
    case (state_q)
      IDLE: begin
        if (MemOK && (|req_valid)) begin
          state_d = ISSUE;
          id_d    = win_id;
          row_d   = win_row;
          wr_d    = win_wr;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!cache_hold) begin
          crow_d  = cache_cRowId;
          state_d = RESP;
        end else if (timeout_hit) begin
          crow_d  = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Accept is combinational so a grant can land in the same cycle MemOK rises.
  always_comb begin
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_crow    = '0;
    cache_RD    = 1'b0;
    cache_WR    = 1'b0;
    cache_RowId = '0;
    if (state_q == IDLE && MemOK && !rst) req_ready = grant;
    if (state_q != IDLE) cache_RowId = row_q;
    if (state_q == ISSUE) begin
      cache_WR = wr_q;
      cache_RD = !wr_q;
    end
    if (state_q == RESP) begin
      rsp_valid[id_q] = 1'b1;
      rsp_crow        = crow_q;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_row_cache_arbiter.sv
// Directed bench for row_cache_arbiter; timeout scenario runs when ROW_CACHE_ARB_TIMEOUT_EN is defined.
module tb_row_cache_arbiter;
  import row_cache_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 17;
  localparam int CRW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_wr, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_row;
  logic [CRW-1:0]    rsp_crow, cache_cRowId;
  logic              rsp_err, MemOK, cache_RD, cache_WR, cache_hold;
  logic [AW-1:0]     cache_RowId;
  state_e            dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  row_cache_arbiter #(.NREQ(NREQ), .ADDRWIDTH(AW), .CROWWIDTH(CRW), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_row(req_row),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_crow(rsp_crow), .rsp_err(rsp_err),
    .MemOK(MemOK), .cache_RD(cache_RD), .cache_WR(cache_WR), .cache_RowId(cache_RowId),
    .cache_hold(cache_hold), .cache_cRowId(cache_cRowId), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_row(input int i, input logic [AW-1:0] v);
    req_row[i*AW +: AW] = v;
  endtask

  // Called in the grant cycle; ends in the RESP cycle. busy = WAIT cycles with hold=1.
  task automatic txn(input logic [3:0] g, input logic [AW-1:0] row, input logic wr,
                     input logic [CRW-1:0] crow, input int busy, input logic exp_err);
    chk("grant", 32'(req_ready), 32'(g));
    chk("grant_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk); cache_cRowId = crow; #1;
    chk("issue_rd", 32'(cache_RD), 32'(!wr));
    chk("issue_wr", 32'(cache_WR), 32'(wr));
    chk("issue_row", 32'(cache_RowId), 32'(row));
    chk("issue_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < busy; k++) begin
      @(negedge clk); cache_hold = 1'b1; #1;
      chk("wait_strobe", 32'({cache_RD, cache_WR}), 32'd0);
      chk("wait_rsp", 32'({rsp_valid, rsp_crow, rsp_err}), 32'd0);
      chk("wait_row", 32'(cache_RowId), 32'(row));
    end
    if (!exp_err) begin
      @(negedge clk); cache_hold = 1'b0; #1;
      chk("wait_exit_state", 32'(dbg_state), 32'(WAIT));
      chk("wait_exit_rsp", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk); cache_hold = 1'b0; #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(g));
    chk("rsp_crow", 32'(rsp_crow), exp_err ? 32'd0 : 32'(crow));
    chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    chk("rsp_row", 32'(cache_RowId), 32'(row));
    chk("rsp_strobe", 32'({cache_RD, cache_WR}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = '1; req_wr = '0; req_row = '0; MemOK = 1'b1;
    cache_hold = 1'b0; cache_cRowId = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outs", 32'({rsp_valid, rsp_crow, rsp_err, cache_RD, cache_WR}), 32'd0);
    chk("rst_row", 32'(cache_RowId), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));

    // Plain read right after reset release.
    @(negedge clk); rst = 1'b0; req_valid = 4'b0001; set_row(0, 17'd150); #1;
    txn(4'b0001, 17'd150, 1'b0, 5'd7, 0, 1'b0);
    @(negedge clk); req_valid = '0; #1;
    chk("idle_row", 32'(cache_RowId), 32'd0);
    chk("idle_rsp", 32'(rsp_valid), 32'd0);

    // Reset during WAIT drops the request and rewinds ptr.
    @(negedge clk); req_valid = 4'b0100; set_row(2, 17'd77); #1;
    chk("w_grant", 32'(req_ready), 32'b0100);
    @(negedge clk); req_valid = '0; #1;
    @(negedge clk); cache_hold = 1'b1; rst = 1'b1; #1;
    chk("w_in_wait", 32'(dbg_state), 32'(WAIT));
    @(negedge clk); #1;
    chk("w_rst_outs", 32'({req_ready, rsp_valid, rsp_crow, rsp_err, cache_RD, cache_WR}), 32'd0);
    chk("w_rst_row", 32'(cache_RowId), 32'd0);
    chk("w_rst_state", 32'(dbg_state), 32'(IDLE));

    // Fairness with all four held, all writes.
    rst = 1'b0; cache_hold = 1'b0; req_valid = 4'b1111; req_wr = 4'b1111;
    set_row(0, 17'd10); set_row(1, 17'd20); set_row(2, 17'd30); set_row(3, 17'd40);
    #1;
    txn(4'b0001, 17'd10, 1'b1, 5'd1, 0, 1'b0);
    @(negedge clk); #1; txn(4'b0010, 17'd20, 1'b1, 5'd2, 0, 1'b0);
    @(negedge clk); #1; txn(4'b0100, 17'd30, 1'b1, 5'd3, 0, 1'b0);
    @(negedge clk); #1; txn(4'b1000, 17'd40, 1'b1, 5'd4, 0, 1'b0);
    @(negedge clk); #1; txn(4'b0001, 17'd10, 1'b1, 5'd5, 0, 1'b0);

    // Cache busy for five WAIT cycles (ptr now 1, only requester 3 valid).
    @(negedge clk); req_valid = 4'b1000; req_wr = '0; #1;
    txn(4'b1000, 17'd40, 1'b0, 5'd19, 5, 1'b0);

    // MemOK low blocks grants; grant lands the cycle it rises.
    @(negedge clk); MemOK = 1'b0; req_valid = 4'b0010; #1;
    chk("memok_blk0", 32'(req_ready), 32'd0);
    @(negedge clk); #1;
    chk("memok_blk1", 32'(req_ready), 32'd0);
    chk("memok_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk); MemOK = 1'b1; #1;
    txn(4'b0010, 17'd20, 1'b0, 5'd3, 0, 1'b0);

    // Requester 2 withdraws before being granted; requester 0 wins.
    @(negedge clk); MemOK = 1'b0; req_valid = 4'b0100; #1;
    chk("drop_blk", 32'(req_ready), 32'd0);
    @(negedge clk); MemOK = 1'b1; req_valid = 4'b0001; #1;
    txn(4'b0001, 17'd10, 1'b0, 5'd30, 0, 1'b0);

`ifdef ROW_CACHE_ARB_TIMEOUT_EN
    // Hold stuck: error response after WAIT cycle 8, then normal service.
    @(negedge clk); req_valid = 4'b0100; set_row(2, 17'd77); #1;
    txn(4'b0100, 17'd77, 1'b0, 5'd9, 8, 1'b1);
    @(negedge clk); req_valid = 4'b0001; #1;
    txn(4'b0001, 17'd10, 1'b0, 5'd11, 0, 1'b0);
`endif

    @(negedge clk); req_valid = '0; #1;
    chk("end_idle", 32'(dbg_state), 32'(IDLE));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
